output_vc_status: RTL and testbench
===================================

Name: output_vc_status

Overview:
- Per-output-port tracker of output-VC (OVC) ownership and downstream credits.
- Sits directly upstream of the combined VC/switch allocator. Its outputs drive the allocator's OVC-availability masking (masked_ovc_request) and the assigned_ovc_not_full inputs.
- Consumes the allocator's per-port OVC grants, the switch traversal of this port's flits, and credits returned by the downstream router.
- One instance per output port; the router instantiates P of them.

Parameters:
- V, 4, VCs per port.
- B, 4, flit buffer depth per VC at the downstream input; the credit counter ceiling.
- CONSERVATIVE_REALLOC, 0, 0 = OVC is freed on tail departure; 1 = OVC is freed only once its credits return to B.
- AVAIL_MASK, {V{1'b1}}, OVCs allowed to be allocated; masked-off OVCs never report available.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ovc_allocated  input  V  one-hot or zero; OVC granted by the allocator this cycle.
- flit_sent  input  1  a flit leaves this port this cycle.
- sent_ovc  input  V  one-hot OVC of the departing flit; valid only when flit_sent=1.
- sent_is_tail  input  1  the departing flit is a tail (or single-flit packet).
- credit_in  input  V  one credit returned per asserted bit.
- ovc_avalable  output  V  OVC is in the FREE state and allowed by AVAIL_MASK.
- ovc_not_full  output  V  OVC credit count is greater than 0.
- credit_cnt_all  output  V*CW  packed credit counters, CW = $clog2(B+1), OVC0 in the LSBs.
- status_err  output  3  sticky error flags: {alloc_err, overflow_err, underflow_err}.

Behaviour:
- Reset, synchronous, one cycle, legal at any time:
  - every counter = B;
  - every OVC in state FREE;
  - ovc_avalable = AVAIL_MASK;
  - ovc_not_full = all 1;
  - status_err = 0.
  - Any in-flight allocation or departure is discarded.
- All outputs are registered. Each reflects the state after the previous clock edge, so there are no combinational input-to-output paths. Latency from any input to its visible effect is 1 cycle.
- Credit counter, per OVC i. Let dec = flit_sent & sent_ovc[i] and inc = credit_in[i]:
  - inc & dec: counter unchanged.
  - inc only: counter +1. If the counter is already B, it holds at B and overflow_err is set.
  - dec only: counter -1. If the counter is already 0, it holds at 0 and underflow_err is set.
  - ovc_not_full[i] is the registered value of (next counter != 0).
- Per-OVC state machine, with states FREE, BUSY, DRAIN:
  - FREE -> BUSY when ovc_allocated[i]=1.
  - FREE, ovc_allocated[i]=1 but AVAIL_MASK[i]=0: the transition still occurs and alloc_err is set.
  - BUSY, ovc_allocated[i]=1: alloc_err is set and the state stays BUSY.
  - BUSY -> FREE on a tail departure (dec & sent_is_tail) when CONSERVATIVE_REALLOC=0.
  - BUSY -> DRAIN on a tail departure when CONSERVATIVE_REALLOC=1.
  - DRAIN -> FREE in the cycle the next counter value equals B. That includes a tail departure whose final credit returns in the same cycle.
  - A tail departure while FREE sets alloc_err; the state stays FREE.
  - A non-tail departure while FREE or DRAIN sets alloc_err; the counter still decrements.
- Simultaneous events on the same OVC:
  - Tail departure and ovc_allocated in the same cycle: alloc_err is set, the departure is processed, and the allocation is ignored.
  - Departure and credit in the same cycle follow the counter rule above.
- A single-flit packet is allocated in cycle t and may depart as a tail in cycle t+1 or later. It is never in the same cycle, because grants precede traversal.
- flit_sent=1 with sent_ovc not one-hot: alloc_err is set and no counter changes.
- status_err bits are sticky until reset.

Test Plan:
- Reset, V=4, B=4, default parameters -> ovc_avalable=4'b1111, ovc_not_full=4'b1111, every counter 4, status_err=0.
- Allocate OVC1, send 4 non-tail flits on OVC1 with no credits -> counter goes 4,3,2,1,0 and ovc_not_full[1]=0 one cycle after the 4th send. A 5th send -> underflow_err=1 and the counter stays 0.
- CONSERVATIVE_REALLOC=0: allocate OVC2, send head then tail -> ovc_avalable[2]=1 one cycle after the tail while the counter is 2.
- CONSERVATIVE_REALLOC=1: same stimulus -> OVC2 stays in DRAIN with ovc_avalable[2]=0. It becomes available one cycle after the second credit_in[2], when the counter reaches 4.
- Send on OVC0 with credit_in[0]=1 in the same cycle -> counter unchanged. credit_in[3] with counter=4 -> overflow_err=1 and the counter stays 4.
- Allocate OVC0 again while BUSY -> alloc_err=1. Assert reset mid-packet -> all states FREE, counters 4, status_err cleared the next cycle.

Source files
------------

// File: rtl/output_vc_status.sv
// Per-output-port OVC ownership and downstream credit tracker.
// Feeds OVC availability and not-full masks to the combined VC/switch allocator.
module output_vc_status #(
  parameter int unsigned    V                    = 4,
  parameter int unsigned    B                    = 4,
  parameter bit             CONSERVATIVE_REALLOC = 1'b0,
  parameter logic [V-1:0]   AVAIL_MASK           = {V{1'b1}}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [V-1:0]                  ovc_allocated,
  input  logic                          flit_sent,
  input  logic [V-1:0]                  sent_ovc,
  input  logic                          sent_is_tail,
  input  logic [V-1:0]                  credit_in,
  output logic [V-1:0]                  ovc_avalable,
  output logic [V-1:0]                  ovc_not_full,
  output logic [V*$clog2(B+1)-1:0]      credit_cnt_all,
  output logic [2:0]                    status_err
);

  localparam int unsigned   CW       = $clog2(B + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(B);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } ovc_state_e;

  ovc_state_e    state_q [V];
  ovc_state_e    state_d [V];
  logic [CW-1:0] cnt_q   [V];
  logic [CW-1:0] cnt_d   [V];

  logic [V-1:0] dec;
  logic [V-1:0] tail_dep;
  logic [V-1:0] alloc_err_v;
  logic [V-1:0] ovf_v;
  logic [V-1:0] udf_v;
  logic         bad_sent;

  // Decode the departing flit; a non-one-hot sent_ovc touches no counter.
  always_comb begin
    bad_sent = flit_sent && !$onehot(sent_ovc);
    dec      = (flit_sent && $onehot(sent_ovc)) ? sent_ovc : '0;
    tail_dep = sent_is_tail ? dec : '0;
  end

  // Per-OVC credit counter and ownership state machine.
  always_comb begin
    alloc_err_v = '0;
    ovf_v       = '0;
    udf_v       = '0;
    for (int i = 0; i < V; i++) begin
      cnt_d[i]   = cnt_q[i];
      state_d[i] = state_q[i];

      if (credit_in[i] && !dec[i]) begin
        if (cnt_q[i] == CNT_FULL) ovf_v[i] = 1'b1;
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec[i] && !credit_in[i]) begin
        if (cnt_q[i] == '0) udf_v[i] = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CW'(1);
      end

      unique case (state_q[i])
        ST_FREE: begin
          if (dec[i]) alloc_err_v[i] = 1'b1;
          // An allocation colliding with a tail departure is dropped.
          if (ovc_allocated[i] && !tail_dep[i]) begin
            state_d[i] = ST_BUSY;
            if (!AVAIL_MASK[i]) alloc_err_v[i] = 1'b1;
          end
        end
        ST_BUSY: begin
          if (ovc_allocated[i]) alloc_err_v[i] = 1'b1;
          if (tail_dep[i]) begin
            if (!CONSERVATIVE_REALLOC || cnt_d[i] == CNT_FULL) state_d[i] = ST_FREE;
            else                                              state_d[i] = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // No packet owns a draining OVC, so any departure or grant is illegal.
          if (dec[i] || ovc_allocated[i]) alloc_err_v[i] = 1'b1;
          if (cnt_d[i] == CNT_FULL) state_d[i] = ST_FREE;
        end
        default: state_d[i] = ST_FREE;
      endcase
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < V; i++) begin
        state_q[i] <= ST_FREE;
        cnt_q[i]   <= CNT_FULL;
      end
      ovc_avalable <= AVAIL_MASK;
      ovc_not_full <= '1;
      status_err   <= '0;
    end else begin
      for (int i = 0; i < V; i++) begin
        state_q[i]      <= state_d[i];
        cnt_q[i]        <= cnt_d[i];
        ovc_avalable[i] <= (state_d[i] == ST_FREE) && AVAIL_MASK[i];
        ovc_not_full[i] <= (cnt_d[i] != '0);
      end
      status_err <= status_err | {(|alloc_err_v) || bad_sent, |ovf_v, |udf_v};
    end
  end

  // Counters are exported straight from their flops.
  always_comb begin
    credit_cnt_all = '0;
    for (int i = 0; i < V; i++) begin
      credit_cnt_all[i*CW +: CW] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_output_vc_status.sv
// Bench for output_vc_status: one eager and one conservative/masked instance
// driven in lockstep, checked against hand vectors and a behavioural model.
module tb_output_vc_status;

  localparam int V  = 4;
  localparam int B  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [V-1:0] ovc_allocated;
  logic         flit_sent;
  logic [V-1:0] sent_ovc;
  logic         sent_is_tail;
  logic [V-1:0] credit_in;

  logic [V-1:0]    av0, nf0, av1, nf1;
  logic [V*CW-1:0] cc0, cc1;
  logic [2:0]      er0, er1;

  output_vc_status #(.V(V), .B(B), .CONSERVATIVE_REALLOC(1'b0), .AVAIL_MASK(4'b1111)) dut0 (
    .clk(clk), .reset(reset), .ovc_allocated(ovc_allocated), .flit_sent(flit_sent),
    .sent_ovc(sent_ovc), .sent_is_tail(sent_is_tail), .credit_in(credit_in),
    .ovc_avalable(av0), .ovc_not_full(nf0), .credit_cnt_all(cc0), .status_err(er0));

  output_vc_status #(.V(V), .B(B), .CONSERVATIVE_REALLOC(1'b1), .AVAIL_MASK(4'b0111)) dut1 (
    .clk(clk), .reset(reset), .ovc_allocated(ovc_allocated), .flit_sent(flit_sent),
    .sent_ovc(sent_ovc), .sent_is_tail(sent_is_tail), .credit_in(credit_in),
    .ovc_avalable(av1), .ovc_not_full(nf1), .credit_cnt_all(cc1), .status_err(er1));

  int checks   = 0;
  int failures = 0;

  // Reference model: counts as plain ints, state 0=free 1=owned 2=draining.
  int       m_cnt [2][V];
  int       m_st  [2][V];
  bit [2:0] m_err [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] pk(input int c3, input int c2, input int c1, input int c0);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  task automatic model_step(input int k);
    bit [3:0] msk;
    bit       cons, onehot, dec, inc, tdep;
    int       nc;
    msk  = (k == 0) ? 4'b1111 : 4'b0111;
    cons = (k == 1);
    if (reset) begin
      for (int i = 0; i < V; i++) begin
        m_cnt[k][i] = B;
        m_st[k][i]  = 0;
      end
      m_err[k] = 3'b000;
      return;
    end
    onehot = ($countones(sent_ovc) == 1);
    if (flit_sent && !onehot) m_err[k][2] = 1'b1;
    for (int i = 0; i < V; i++) begin
      dec  = flit_sent && onehot && sent_ovc[i];
      inc  = credit_in[i];
      tdep = dec && sent_is_tail;
      nc   = m_cnt[k][i];
      if (inc && !dec) begin
        if (nc == B) m_err[k][1] = 1'b1; else nc = nc + 1;
      end else if (dec && !inc) begin
        if (nc == 0) m_err[k][0] = 1'b1; else nc = nc - 1;
      end
      if (m_st[k][i] == 0) begin
        if (dec) m_err[k][2] = 1'b1;
        if (ovc_allocated[i] && !tdep) begin
          m_st[k][i] = 1;
          if (!msk[i]) m_err[k][2] = 1'b1;
        end
      end else if (m_st[k][i] == 1) begin
        if (ovc_allocated[i]) m_err[k][2] = 1'b1;
        if (tdep) m_st[k][i] = (!cons || nc == B) ? 0 : 2;
      end else begin
        if (dec || ovc_allocated[i]) m_err[k][2] = 1'b1;
        if (nc == B) m_st[k][i] = 0;
      end
      m_cnt[k][i] = nc;
    end
  endtask

  task automatic model_cmp(input int k, input logic [3:0] av, input logic [3:0] nf,
                           input logic [11:0] cc, input logic [2:0] er);
    logic [3:0] e_av, e_nf, msk;
    msk = (k == 0) ? 4'b1111 : 4'b0111;
    for (int i = 0; i < V; i++) begin
      e_av[i] = (m_st[k][i] == 0) && msk[i];
      e_nf[i] = (m_cnt[k][i] != 0);
    end
    chk($sformatf("model%0d_avail", k), 32'(av), 32'(e_av));
    chk($sformatf("model%0d_notfull", k), 32'(nf), 32'(e_nf));
    chk($sformatf("model%0d_cnt", k), 32'(cc),
        32'(pk(m_cnt[k][3], m_cnt[k][2], m_cnt[k][1], m_cnt[k][0])));
    chk($sformatf("model%0d_err", k), 32'(er), 32'(m_err[k]));
  endtask

  // Drive one cycle of inputs, then compare both instances with the model.
  task automatic drive(input logic r, input logic [3:0] a, input logic fs,
                       input logic [3:0] so, input logic tl, input logic [3:0] cr);
    reset = r; ovc_allocated = a; flit_sent = fs;
    sent_ovc = so; sent_is_tail = tl; credit_in = cr;
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    model_cmp(0, av0, nf0, cc0, er0);
    model_cmp(1, av1, nf1, cc1, er1);
  endtask

  typedef struct {
    logic       r;
    logic [3:0] a;
    logic       fs;
    logic [3:0] so;
    logic       tl;
    logic [3:0] cr;
    logic [3:0] e_av;
    logic [3:0] e_nf;
    logic [11:0] e_cc;
    logic [2:0] e_er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [3:0] a, input logic fs,
                              input logic [3:0] so, input logic tl, input logic [3:0] cr,
                              input logic [3:0] e_av, input logic [3:0] e_nf,
                              input logic [11:0] e_cc, input logic [2:0] e_er);
    vec_t v;
    v.r = r; v.a = a; v.fs = fs; v.so = so; v.tl = tl; v.cr = cr;
    v.e_av = e_av; v.e_nf = e_nf; v.e_cc = e_cc; v.e_er = e_er;
    return v;
  endfunction

  initial begin
    reset = 1'b1; ovc_allocated = '0; flit_sent = 1'b0;
    sent_ovc = '0; sent_is_tail = 1'b0; credit_in = '0;

    // Eager instance vectors: r a fs so tl cr | avail notfull counters err
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b1111, 4'b1111, pk(4,4,4,4), 3'b000));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 0, 4'b0000, 4'b1101, 4'b1111, pk(4,4,4,4), 3'b000));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0010, 0, 4'b0000, 4'b1101, 4'b1111, pk(4,4,3,4), 3'b000));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0010, 0, 4'b0000, 4'b1101, 4'b1111, pk(4,4,2,4), 3'b000));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0010, 0, 4'b0000, 4'b1101, 4'b1111, pk(4,4,1,4), 3'b000));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0010, 0, 4'b0000, 4'b1101, 4'b1101, pk(4,4,0,4), 3'b000));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0010, 0, 4'b0000, 4'b1101, 4'b1101, pk(4,4,0,4), 3'b001));
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b1111, 4'b1111, pk(4,4,4,4), 3'b000));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0000, 0, 4'b0000, 4'b1011, 4'b1111, pk(4,4,4,4), 3'b000));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0100, 0, 4'b0000, 4'b1011, 4'b1111, pk(4,3,4,4), 3'b000));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0100, 1, 4'b0000, 4'b1111, 4'b1111, pk(4,2,4,4), 3'b000));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 4'b1110, 4'b1111, pk(4,2,4,4), 3'b000));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0001, 0, 4'b0001, 4'b1110, 4'b1111, pk(4,2,4,4), 3'b000));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 4'b1000, 4'b1110, 4'b1111, pk(4,2,4,4), 3'b010));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 4'b0100, 4'b1110, 4'b1111, pk(4,3,4,4), 3'b010));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 4'b1110, 4'b1111, pk(4,3,4,4), 3'b110));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 4'b1110, 4'b1111, pk(4,3,4,3), 3'b110));
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b1111, 4'b1111, pk(4,4,4,4), 3'b000));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b1111, 4'b1111, pk(4,4,4,4), 3'b000));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0011, 0, 4'b0000, 4'b1111, 4'b1111, pk(4,4,4,4), 3'b100));

    foreach (tbl[n]) begin
      drive(tbl[n].r, tbl[n].a, tbl[n].fs, tbl[n].so, tbl[n].tl, tbl[n].cr);
      chk($sformatf("vec%0d_avail", n), 32'(av0), 32'(tbl[n].e_av));
      chk($sformatf("vec%0d_notfull", n), 32'(nf0), 32'(tbl[n].e_nf));
      chk($sformatf("vec%0d_cnt", n), 32'(cc0), 32'(tbl[n].e_cc));
      chk($sformatf("vec%0d_err", n), 32'(er0), 32'(tbl[n].e_er));
    end

    // Conservative instance: OVC2 drains until both credits return.
    drive(1, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    chk("cons_reset_avail", 32'(av1), 32'(4'b0111));
    drive(0, 4'b0100, 0, 4'b0000, 0, 4'b0000);
    chk("cons_alloc_avail", 32'(av1), 32'(4'b0011));
    drive(0, 4'b0000, 1, 4'b0100, 0, 4'b0000);
    drive(0, 4'b0000, 1, 4'b0100, 1, 4'b0000);
    chk("cons_drain_avail", 32'(av1), 32'(4'b0011));
    chk("cons_drain_cnt", 32'(cc1), 32'(pk(4,2,4,4)));
    chk("eager_tail_avail", 32'(av0), 32'(4'b1111));
    drive(0, 4'b0000, 0, 4'b0000, 0, 4'b0100);
    chk("cons_cred1_avail", 32'(av1), 32'(4'b0011));
    drive(0, 4'b0000, 0, 4'b0000, 0, 4'b0100);
    chk("cons_cred2_avail", 32'(av1), 32'(4'b0111));
    chk("cons_cred2_cnt", 32'(cc1), 32'(pk(4,4,4,4)));

    // Tail leaving together with the credit that refills the counter skips DRAIN.
    drive(0, 4'b0100, 0, 4'b0000, 0, 4'b0000);
    drive(0, 4'b0000, 1, 4'b0100, 0, 4'b0000);
    drive(0, 4'b0000, 0, 4'b0000, 0, 4'b0100);
    chk("cons_busy_full_avail", 32'(av1), 32'(4'b0011));
    drive(0, 4'b0000, 1, 4'b0100, 1, 4'b0100);
    chk("cons_tail_credit_avail", 32'(av1), 32'(4'b0111));
    chk("cons_clean_err", 32'(er1), 32'(3'b000));

    // Granting a masked-off OVC still takes it but flags the error.
    drive(0, 4'b1000, 0, 4'b0000, 0, 4'b0000);
    chk("mask_alloc_err", 32'(er1), 32'(3'b100));
    chk("mask_alloc_avail", 32'(av1), 32'(4'b0111));
    chk("eager_alloc3_avail", 32'(av0), 32'(4'b0111));

    // Random traffic with occasional resets, checked against the model.
    drive(1, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    for (int c = 0; c < 3000; c++) begin
      logic       r, fs, tl;
      logic [3:0] a, so, cr;
      r  = ($urandom_range(0, 59) == 0);
      a  = ($urandom_range(0, 3) == 0) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      fs = ($urandom_range(0, 1) == 1);
      so = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'(4'b0001 << $urandom_range(0, 3));
      tl = ($urandom_range(0, 2) == 0);
      cr = 4'($urandom) & 4'($urandom);
      drive(r, a, fs, so, tl, cr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
